// File: rtl/frame_fifo_write_mb.sv
// frame_fifo_write_mb: drains the capture-side clock-crossing FIFO into
// external memory through the memory controller burst-write port. Frames of
// any length are split into bursts of up to BURST_SIZE words, with the last
// burst truncated to whatever remains. NUM_BUFS = 2**IDX_BITS base addresses
// are selectable per frame.
// Optional build macro: FRAME_WRITE_STATUS_EN adds burst_cnt / frame_cnt
// status outputs; without it those ports and registers do not exist.
module frame_fifo_write_mb #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 128,
  parameter int IDX_BITS      = 2
) (
  input  logic                                  mem_clk,
  input  logic                                  rst_n,
  input  logic                                  write_req,
  output logic                                  write_req_ack,
  output logic                                  write_finish,
  output logic                                  busy,
  input  logic [(2**IDX_BITS)*ADDR_BITS-1:0]    write_addr,
  input  logic [IDX_BITS-1:0]                   write_addr_index,
  input  logic [ADDR_BITS-1:0]                  write_len,
  output logic                                  fifo_aclr,
  input  logic [15:0]                           rdusedw,
  output logic                                  wr_burst_req,
  output logic [BURST_BITS-1:0]                 wr_burst_len,
  output logic [ADDR_BITS-1:0]                  wr_burst_addr,
  input  logic                                  wr_burst_data_req,
  input  logic                                  wr_burst_finish
`ifdef FRAME_WRITE_STATUS_EN
  ,
  output logic [15:0]                           burst_cnt,
  output logic [15:0]                           frame_cnt
`endif
);

  localparam int NUM_BUFS = 2**IDX_BITS;
  localparam int CMP_BITS = (ADDR_BITS > 16) ? ADDR_BITS : 16;
  localparam logic [ADDR_BITS-1:0] BURST_SIZE_W = ADDR_BITS'(BURST_SIZE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACK       = 3'd1,
    S_CHECK     = 3'd2,
    S_BURST     = 3'd3,
    S_BURST_END = 3'd4,
    S_END       = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [2:0]           req_sync_q;
  logic [ADDR_BITS-1:0] len_sync1_q, len_sync2_q;
  logic [IDX_BITS-1:0]  idx_sync1_q, idx_sync2_q;
  logic                 req_s;
  logic [ADDR_BITS-1:0] len_s;
  logic [IDX_BITS-1:0]  idx_s;

  logic                  ack_q, ack_d;
  logic                  aclr_q, aclr_d;
  logic                  finish_q, finish_d;
  logic                  burst_req_q, burst_req_d;
  logic [BURST_BITS-1:0] burst_len_q, burst_len_d;
  logic [ADDR_BITS-1:0]  burst_addr_q, burst_addr_d;
  logic [ADDR_BITS-1:0]  len_latch_q, len_latch_d;
  logic [ADDR_BITS-1:0]  write_cnt_q, write_cnt_d;

  logic [ADDR_BITS-1:0]  rem;
  logic [ADDR_BITS-1:0]  blen;
  logic [ADDR_BITS-1:0]  base_addr [NUM_BUFS];

`ifdef FRAME_WRITE_STATUS_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  // The data strobe and word width are informational only; fold them into a
  // deliberately unused net so they do not look forgotten.
  logic unused_ok;
  assign unused_ok = &{1'b0, wr_burst_data_req, (MEM_DATA_BITS > 0)};

  // Bring the request, length and buffer index into the mem_clk domain.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      req_sync_q  <= '0;
      len_sync1_q <= '0;
      len_sync2_q <= '0;
      idx_sync1_q <= '0;
      idx_sync2_q <= '0;
    end else begin
      req_sync_q  <= {req_sync_q[1:0], write_req};
      len_sync1_q <= write_len;
      len_sync2_q <= len_sync1_q;
      idx_sync1_q <= write_addr_index;
      idx_sync2_q <= idx_sync1_q;
    end
  end

  assign req_s = req_sync_q[2];
  assign len_s = len_sync2_q;
  assign idx_s = idx_sync2_q;

  // Unpack the flattened base-address bus so the selected buffer can be
  // indexed directly by the synchronised index.
  always_comb begin
    for (int k = 0; k < NUM_BUFS; k++) begin
      base_addr[k] = write_addr[k*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Next burst size: whatever is left of the frame, capped at BURST_SIZE.
  // Kept at full address width so truncation only happens after the min.
  always_comb begin
    rem  = len_latch_q - write_cnt_q;
    blen = (rem < BURST_SIZE_W) ? rem : BURST_SIZE_W;
  end

  // Frame sequencing: handshake, burst issue/completion and frame end.
  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    aclr_d       = aclr_q;
    burst_req_d  = burst_req_q;
    burst_len_d  = burst_len_q;
    burst_addr_d = burst_addr_q;
    len_latch_d  = len_latch_q;
    write_cnt_d  = write_cnt_q;
`ifdef FRAME_WRITE_STATUS_EN
    burst_cnt_d  = burst_cnt_q;
    frame_cnt_d  = frame_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
`ifdef FRAME_WRITE_STATUS_EN
        burst_cnt_d = '0;
`endif
        if (req_s) begin
          ack_d        = 1'b1;
          aclr_d       = 1'b1;
          burst_addr_d = base_addr[idx_s];
          len_latch_d  = len_s;
          write_cnt_d  = '0;
        end else begin
          ack_d   = 1'b0;
          aclr_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (req_s) begin
          state_d = S_ACK;
        end else if (write_cnt_q >= len_latch_q) begin
          state_d = S_END;
        end else if (CMP_BITS'(rdusedw) >= CMP_BITS'(blen)) begin
          burst_len_d = blen[BURST_BITS-1:0];
          burst_req_d = 1'b1;
          state_d     = S_BURST;
        end
      end
      S_BURST: begin
        if (wr_burst_finish) begin
          burst_req_d  = 1'b0;
          write_cnt_d  = write_cnt_q + ADDR_BITS'(burst_len_q);
          burst_addr_d = burst_addr_q + ADDR_BITS'(burst_len_q);
          state_d      = S_BURST_END;
`ifdef FRAME_WRITE_STATUS_EN
          burst_cnt_d  = burst_cnt_q + 16'd1;
`endif
        end
      end
      S_BURST_END: begin
        if (req_s) begin
          state_d = S_ACK;
        end else if (write_cnt_q < len_latch_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
`ifdef FRAME_WRITE_STATUS_EN
        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    finish_d = (state_d == S_END);
  end

  // State and output registers; reset clears everything including an
  // in-flight burst request.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      aclr_q       <= 1'b0;
      finish_q     <= 1'b0;
      burst_req_q  <= 1'b0;
      burst_len_q  <= '0;
      burst_addr_q <= '0;
      len_latch_q  <= '0;
      write_cnt_q  <= '0;
`ifdef FRAME_WRITE_STATUS_EN
      burst_cnt_q  <= '0;
      frame_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      aclr_q       <= aclr_d;
      finish_q     <= finish_d;
      burst_req_q  <= burst_req_d;
      burst_len_q  <= burst_len_d;
      burst_addr_q <= burst_addr_d;
      len_latch_q  <= len_latch_d;
      write_cnt_q  <= write_cnt_d;
`ifdef FRAME_WRITE_STATUS_EN
      burst_cnt_q  <= burst_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign write_req_ack = ack_q;
  assign fifo_aclr     = aclr_q;
  assign write_finish  = finish_q;
  assign wr_burst_req  = burst_req_q;
  assign wr_burst_len  = burst_len_q;
  assign wr_burst_addr = burst_addr_q;
  assign busy          = (state_q != S_IDLE);
`ifdef FRAME_WRITE_STATUS_EN
  assign burst_cnt     = burst_cnt_q;
  assign frame_cnt     = frame_cnt_q;
`endif

endmodule

// File: doc/frame_fifo_write_mb.md
Name: frame_fifo_write_mb

Overview:
Parametrised multi-buffer frame writer. It drains a clock-domain-crossing FIFO into external memory through the memory controller burst-write interface. Frame length no longer needs to be a multiple of the burst size: the last burst is truncated to the remaining words. It sits between the capture-side FIFO (read side on mem_clk) and the memory controller write port.

Parameters:
MEM_DATA_BITS, 32, memory word width (pass-through, documentation only)
ADDR_BITS, 23, word address / length width
BURST_BITS, 10, wr_burst_len width
BURST_SIZE, 128, maximum burst length in words; must be at least 1 and below 2**BURST_BITS
IDX_BITS, 2, buffer index width; NUM_BUFS = 2**IDX_BITS base addresses

Ports:
mem_clk  in  1  memory controller user clock; only clock
rst_n  in  1  synchronous active-low reset
write_req  in  1  asynchronous frame request; held until write_req_ack
write_req_ack  out  1  request acknowledge
write_finish  out  1  one-cycle pulse when a frame completes
busy  out  1  high whenever state != S_IDLE
write_addr  in  NUM_BUFS*ADDR_BITS  flattened base addresses; buffer k = bits [k*ADDR_BITS +: ADDR_BITS]
write_addr_index  in  IDX_BITS  selects base address (asynchronous)
write_len  in  ADDR_BITS  frame length in words (asynchronous)
fifo_aclr  out  1  FIFO clear, held during acknowledge
rdusedw  in  16  FIFO words available
wr_burst_req  out  1  burst request to controller
wr_burst_len  out  BURST_BITS  burst length
wr_burst_addr  out  ADDR_BITS  burst base address
wr_burst_data_req  in  1  controller data strobe (unused internally)
wr_burst_finish  in  1  controller burst complete

Behaviour:
- Reset (rst_n low at a mem_clk edge): all outputs 0, state S_IDLE, all synchroniser and latch registers 0.
- Synchronisers: write_req passes through 3 flops to give req_s. write_len and write_addr_index pass through 2 flops each.
- S_IDLE: write_req_ack=0. If req_s, go to S_ACK.
- S_ACK, req_s=1: write_req_ack=1, fifo_aclr=1, latch wr_burst_addr=write_addr[idx_s], latch len_latch=len_s, write_cnt=0.
- S_ACK, req_s=0: write_req_ack=0, fifo_aclr=0, go to S_CHECK.
- S_CHECK, priority order:
  - req_s: go to S_ACK.
  - write_cnt >= len_latch (covers len=0): go to S_END.
  - Otherwise compute rem = len_latch - write_cnt and blen = min(BURST_SIZE, rem). If rdusedw >= blen: wr_burst_len=blen, wr_burst_req=1, go to S_BURST. Else stay in S_CHECK.
- S_BURST:
  - write_req is ignored here; an issued burst is never aborted.
  - On wr_burst_finish: wr_burst_req=0, write_cnt += wr_burst_len, wr_burst_addr += wr_burst_len (mod 2**ADDR_BITS, wrap silently), go to S_BURST_END.
- S_BURST_END: if req_s go to S_ACK; else if write_cnt < len_latch go to S_CHECK; else go to S_END.
- S_END: write_finish=1 for exactly this cycle, then go to S_IDLE.
- Unused state encodings go to S_IDLE.
- Width rule: rem and blen are computed at ADDR_BITS width, and blen is truncated to BURST_BITS only after the min.
- Comparisons against rdusedw are zero-extended to max(16, ADDR_BITS).
- Request latency: a write_req rise reaches S_ACK 4 mem_clk edges later.
- Reset mid-burst: wr_burst_req drops to 0 on the reset edge. The controller is responsible for its own recovery.

Optional Feature:
FRAME_WRITE_STATUS_EN
- Defined: adds output burst_cnt[15:0], which clears in S_ACK and increments on each wr_burst_finish in S_BURST.
- Defined: adds output frame_cnt[15:0], which increments in S_END, wraps at 16 bits, and clears only on reset.
- Not defined: both ports and their registers are absent; all other behaviour is identical.

Test Plan:
- len=512, BURST_SIZE=128, idx=2, addr2=0x1000, rdusedw=200 -> 4 bursts of len 128 at 0x1000/0x1080/0x1100/0x1180; write_finish pulses once, 1 cycle.
- len=300 -> bursts 128, 128, 44; third burst issued only once rdusedw >= 44; final wr_burst_addr = base+300.
- len=0 -> ack handshake completes, no wr_burst_req, write_finish pulses.
- New write_req asserted during the 2nd burst -> that burst completes; at S_BURST_END go to S_ACK, fifo_aclr=1, write_cnt=0, base re-latched.
- Base 0x7FFF80, ADDR_BITS=23, len=256 -> second burst address wraps to 0x000000.
- rst_n low mid-burst for 1 cycle -> next edge all outputs 0, state S_IDLE; with FRAME_WRITE_STATUS_EN, frame_cnt=0.
